// File: rtl/alu_seq.sv
// Sequential ALU with a ready/valid command port and a ready/valid result port.
// Single-cycle ops complete on the accept edge; mul (radix-2 Booth) and div
// (restoring, on magnitudes) take WIDTH iterations in CALC before presenting.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [4:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpShr  = 5'b00111;
    localparam logic [4:0] OpShra = 5'b01000;
    localparam logic [4:0] OpShl  = 5'b01001;
    localparam logic [4:0] OpRor  = 5'b01010;
    localparam logic [4:0] OpRol  = 5'b01011;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e               state_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 err_q;
    logic [CW-1:0]        cnt_q;
    logic                 is_div_q;
    // Booth: acc_q is the (WIDTH+1)-bit upper partial product, mq_q the multiplier.
    // Div:   acc_q holds the partial remainder, mq_q the dividend/quotient.
    logic [WIDTH:0]       acc_q;
    logic [WIDTH-1:0]     mq_q;
    logic                 qm1_q;
    logic [WIDTH-1:0]     m_q;
    logic                 qneg_q;
    logic                 rneg_q;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign err       = err_q;

    // Single-cycle datapath, evaluated on the operands presented at accept
    logic [WIDTH:0]       add_s, sub_s, neg_s;
    logic [SHW-1:0]       shamt;
    logic [2*WIDTH-1:0]   rot2, ror_w, rol_w;
    logic [WIDTH-1:0]     shra_w;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [2*WIDTH-1:0]   single_res;
    logic                 single_err;
    logic                 is_iter;

    // Decode the op and produce the single-cycle result / error
    always_comb begin
        add_s      = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        sub_s      = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        neg_s      = {(WIDTH+1){1'b0}} - {a[WIDTH-1], a};
        shamt      = b[SHW-1:0];
        rot2       = {a, a};
        ror_w      = rot2 >> shamt;
        rol_w      = rot2 << shamt;
        shra_w     = $signed(a) >>> shamt;
        abs_a      = a[WIDTH-1] ? (-a) : a;
        abs_b      = b[WIDTH-1] ? (-b) : b;
        single_res = '0;
        single_err = 1'b0;
        is_iter    = 1'b0;
        case (op)
            OpAdd:  single_res = {{(WIDTH-1){add_s[WIDTH]}}, add_s};
            OpSub:  single_res = {{(WIDTH-1){sub_s[WIDTH]}}, sub_s};
            OpNeg:  single_res = {{(WIDTH-1){neg_s[WIDTH]}}, neg_s};
            OpAnd:  single_res = {{WIDTH{1'b0}}, a & b};
            OpOr:   single_res = {{WIDTH{1'b0}}, a | b};
            OpNot:  single_res = {{WIDTH{1'b0}}, ~a};
            OpShr:  single_res = {{WIDTH{1'b0}}, a >> shamt};
            OpShra: single_res = {{WIDTH{1'b0}}, shra_w};
            OpShl:  single_res = {{WIDTH{1'b0}}, a << shamt};
            OpRor:  single_res = {{WIDTH{1'b0}}, ror_w[WIDTH-1:0]};
            OpRol:  single_res = {{WIDTH{1'b0}}, rol_w[2*WIDTH-1:WIDTH]};
            OpMul:  is_iter = 1'b1;
            OpDiv: begin
                if (b == '0) begin
                    single_res = {a, {WIDTH{1'b1}}};
                    single_err = 1'b1;
                end else begin
                    is_iter = 1'b1;
                end
            end
            default: single_err = 1'b1;
        endcase
    end

    // One iteration step of Booth multiply and restoring divide
    logic [WIDTH:0]       booth_m, booth_sum;
    logic [WIDTH:0]       mul_acc_n;
    logic [WIDTH-1:0]     mul_mq_n;
    logic [WIDTH:0]       div_sh;
    logic [WIDTH+1:0]     div_diff;
    logic                 div_ok;
    logic [WIDTH:0]       div_acc_n;
    logic [WIDTH-1:0]     div_mq_n;
    logic [WIDTH-1:0]     div_quot, div_rem;

    // Next iteration values plus sign fix-up of the final quotient/remainder
    always_comb begin
        booth_m = {m_q[WIDTH-1], m_q};
        case ({mq_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + booth_m;
            2'b10:   booth_sum = acc_q - booth_m;
            default: booth_sum = acc_q;
        endcase
        mul_acc_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mul_mq_n  = {booth_sum[0], mq_q[WIDTH-1:1]};

        div_sh    = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
        div_diff  = {1'b0, div_sh} - {2'b00, m_q};
        div_ok    = ~div_diff[WIDTH+1];
        div_acc_n = div_ok ? div_diff[WIDTH:0] : div_sh;
        div_mq_n  = {mq_q[WIDTH-2:0], div_ok};
        div_quot  = qneg_q ? (-div_mq_n) : div_mq_n;
        div_rem   = rneg_q ? (-div_acc_n[WIDTH-1:0]) : div_acc_n[WIDTH-1:0];
    end

    // Control FSM with registered result/err and iteration state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            acc_q    <= '0;
            mq_q     <= '0;
            qm1_q    <= 1'b0;
            m_q      <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (is_iter) begin
                            state_q  <= StCalc;
                            cnt_q    <= '0;
                            acc_q    <= '0;
                            qm1_q    <= 1'b0;
                            is_div_q <= (op == OpDiv);
                            if (op == OpDiv) begin
                                mq_q   <= abs_a;
                                m_q    <= abs_b;
                                qneg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                                rneg_q <= a[WIDTH-1];
                            end else begin
                                mq_q   <= b;
                                m_q    <= a;
                                qneg_q <= 1'b0;
                                rneg_q <= 1'b0;
                            end
                        end else begin
                            state_q  <= StDone;
                            result_q <= single_res;
                            err_q    <= single_err;
                        end
                    end
                end
                StCalc: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (is_div_q) begin
                        acc_q <= div_acc_n;
                        mq_q  <= div_mq_n;
                    end else begin
                        acc_q <= mul_acc_n;
                        mq_q  <= mul_mq_n;
                        qm1_q <= mq_q[0];
                    end
                    // The last iteration lands directly in DONE with the final value
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q  <= StDone;
                        err_q    <= 1'b0;
                        result_q <= is_div_q ? {div_rem, div_quot}
                                             : {mul_acc_n[WIDTH-1:0], mul_mq_n};
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32.
module tb_alu_seq;

    localparam int W = 32;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [4:0]      op;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  result;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one command and return #1 after its accept edge
    task automatic send(input logic [4:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        op       = o;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Take the presented result and check the block is back to IDLE
    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic single(input string tag, input logic [4:0] o, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic [63:0] er, input logic ee);
        send(o, va, vb);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_res"}, result, er);
        chk({tag, "_err"}, {63'd0, err}, {63'd0, ee});
        drain(tag);
    endtask

    // Iterative op: out_valid must rise exactly W edges after accept
    task automatic multi(input string tag, input logic [4:0] o, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input logic [63:0] er);
        int n;
        send(o, va, vb);
        chk({tag, "_busy"}, {63'd0, in_ready}, 64'd0);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            if (!out_valid) n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(W));
        chk({tag, "_res"}, result, er);
        chk({tag, "_err"}, {63'd0, err}, 64'd0);
        drain(tag);
    endtask

    logic [63:0] held_res;
    logic        held_err;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        #12;
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_res", result, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        single("add", 5'b00011, 32'd5, 32'd3, 64'd8, 1'b0);
        single("sub", 5'b00100, 32'd3, 32'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        single("add_ovf", 5'b00011, 32'h7FFF_FFFF, 32'd1, 64'h0000_0000_8000_0000, 1'b0);
        single("and", 5'b00101, 32'hFF00_FF00, 32'h0F0F_0F0F, 64'h0F00_0F00, 1'b0);
        single("or", 5'b00110, 32'hFF00_FF00, 32'h0F0F_0F0F, 64'hFF0F_FF0F, 1'b0);
        single("not", 5'b10010, 32'h0000_FFFF, 32'd0, 64'hFFFF_0000, 1'b0);
        single("shr", 5'b00111, 32'h8000_0000, 32'd4, 64'h0800_0000, 1'b0);
        single("shra", 5'b01000, 32'h8000_0000, 32'd4, 64'hF800_0000, 1'b0);
        single("shl", 5'b01001, 32'd1, 32'd33, 64'd2, 1'b0);
        single("ror", 5'b01010, 32'd1, 32'd1, 64'h8000_0000, 1'b0);
        single("rol", 5'b01011, 32'h8000_0001, 32'd4, 64'h0000_0018, 1'b0);
        single("neg", 5'b10001, 32'd5, 32'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
        single("neg_min", 5'b10001, 32'h8000_0000, 32'd0, 64'h0000_0000_8000_0000, 1'b0);
        single("illegal0", 5'b00000, 32'd7, 32'd9, 64'd0, 1'b1);
        single("illegal1f", 5'b11111, 32'd7, 32'd9, 64'd0, 1'b1);
        single("div0", 5'b10000, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF, 1'b1);

        multi("mul_6x3", 5'b01111, 32'd6, 32'd3, 64'd18);
        multi("mul_m7x3", 5'b01111, -32'sd7, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB);
        multi("mul_minmin", 5'b01111, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        multi("mul_m1m1", 5'b01111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        multi("div_7_m2", 5'b10000, 32'd7, -32'sd2, 64'h0000_0001_FFFF_FFFD);
        multi("div_m7_2", 5'b10000, -32'sd7, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        multi("div_100_7", 5'b10000, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
        multi("div_min_m1", 5'b10000, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

        // Backpressure: result held, no accept while in_valid stays high
        send(5'b00011, 32'd100, 32'd23);
        held_res = result;
        held_err = err;
        chk("bp_first", held_res, 64'd123);
        @(negedge clk);
        op       = 5'b00100;
        a        = 32'd1;
        b        = 32'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_res", result, held_res);
            chk("bp_err", {63'd0, err}, {63'd0, held_err});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk("bp_no_accept", {63'd0, out_valid}, 64'd0);

        // Previous result is nonzero so a reset clear is observable
        single("pre_rst", 5'b00000, 32'd0, 32'd0, 64'd0, 1'b1);
        single("pre_rst2", 5'b00011, 32'd40, 32'd2, 64'd42, 1'b0);
        send(5'b01111, 32'd6, 32'd7);
        for (int i = 0; i < 9; i++) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_res", result, 64'd0);
        chk("arst_err", {63'd0, err}, 64'd0);
        chk("arst_ready", {63'd0, in_ready}, 64'd1);
        // Commands presented during reset are ignored
        op       = 5'b00011;
        a        = 32'd3;
        b        = 32'd4;
        in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("arst_hold_valid", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            chk("arst_discard", {63'd0, out_valid}, 64'd0);
        end
        single("post_rst_add", 5'b00011, 32'd1, 32'd1, 64'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
